// File: rtl/fsm_trig_pkg.sv
// rtl/fsm_trig_pkg.sv - shared state encoding and reset values for the match trigger
package fsm_trig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_COUNT = 3'd2,
        ST_FIRE  = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    // y is built by replicating this bit to the configured width at reset
    localparam logic Y_RST_BIT = 1'b0;
    localparam logic TRIG_RST  = 1'b0;

endpackage

// File: rtl/fsm_trig_match_cnt.sv
// rtl/fsm_trig_match_cnt.sv - saturating match counter; clr and inc together load one
module fsm_trig_match_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

    always_comb begin
        cnt_base = clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (inc && (cnt_base != '1)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fsm_trig_bench.sv
// rtl/fsm_trig_bench.sv - masked-compare trigger FSM; FSM_TRIG_STICKY_EN makes HOLD exit only by reset
module fsm_trig_bench
    import fsm_trig_pkg::*;
#(
    parameter int XW     = 13,
    parameter int YW     = 20,
    parameter int CNT_W  = 4,
    parameter int THRESH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [XW-1:0]    x,
    input  logic [XW-1:0]    match_mask,
    input  logic [XW-1:0]    match_val,
    output logic [YW-1:0]    y,
    output logic [CNT_W-1:0] cnt,
    output logic             trig,
    output logic [2:0]       st
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    state_e           state_q, state_d;
    logic [YW-1:0]    y_q, y_d;
    logic             trig_q, trig_d;
    logic             match, clr, inc;
    logic [CNT_W-1:0] cnt_cur, cnt_sat, cnt_base, cnt_nxt;

    fsm_trig_match_cnt #(.CNT_W(CNT_W)) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (inc),
        .cnt (cnt_cur)
    );

    assign match   = ((x & match_mask) == (match_val & match_mask));
    assign cnt_sat = (cnt_cur == '1) ? cnt_cur : cnt_cur + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clr = 1'b1;
                if (en) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    clr     = 1'b1;
                end else if (match) begin
                    clr     = 1'b1;
                    inc     = 1'b1;
                    state_d = (THRESH == 1) ? ST_FIRE : ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    clr     = 1'b1;
                end else if (match) begin
                    inc = 1'b1;
                    if (cnt_sat >= THRESH_C) state_d = ST_FIRE;
                end
            end
            ST_FIRE: state_d = ST_HOLD;
            ST_HOLD: begin
`ifdef FSM_TRIG_STICKY_EN
                state_d = ST_HOLD;
`else
                if (!en) begin
                    state_d = ST_IDLE;
                    clr     = 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                clr     = 1'b1;
            end
        endcase
    end

    // y mirrors the counter value the submodule is about to hold, so both update together
    always_comb begin
        cnt_base = clr ? '0 : cnt_cur;
        cnt_nxt  = cnt_base;
        if (inc && (cnt_base != '1)) cnt_nxt = cnt_base + CNT_W'(1);
        y_d    = {YW{Y_RST_BIT}};
        trig_d = (state_d == ST_FIRE);
        case (state_d)
            ST_ARM, ST_COUNT: begin
                y_d[0]       = 1'b1;
                y_d[CNT_W:1] = cnt_nxt;
            end
            ST_FIRE, ST_HOLD: y_d = '1;
            default:          y_d = {YW{Y_RST_BIT}};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            y_q     <= {YW{Y_RST_BIT}};
            trig_q  <= TRIG_RST;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            trig_q  <= trig_d;
        end
    end

    assign y    = y_q;
    assign cnt  = cnt_cur;
    assign trig = trig_q;
    assign st   = state_q;

endmodule

// File: tb/tb_fsm_trig_bench.sv
// tb/tb_fsm_trig_bench.sv - scoreboard bench for fsm_trig_bench (default and THRESH=1 instances)
module tb_fsm_trig_bench;

    localparam int XW = 13;
    localparam int YW = 20;
    localparam int CW = 4;
    localparam logic [XW-1:0] MASK = 13'h1F0F;
    localparam logic [XW-1:0] VAL  = 13'h0A05;
    localparam logic [XW-1:0] XM   = 13'h0AF5;
    localparam logic [XW-1:0] XM2  = 13'h0AA5;
    localparam logic [XW-1:0] XN   = 13'h0A04;

    typedef struct packed {
        logic [2:0]    st;
        logic [CW-1:0] cnt;
        logic          trig;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, en0, en1;
    logic [XW-1:0] x, mask, val;
    logic [YW-1:0] y0, y1;
    logic [CW-1:0] cnt0, cnt1;
    logic          trig0, trig1;
    logic [2:0]    st0, st1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_chk = 0;
    int   n_pass = 0;

    fsm_trig_bench u_dut0 (
        .clk(clk), .rst(rst_n), .en(en0), .x(x), .match_mask(mask), .match_val(val),
        .y(y0), .cnt(cnt0), .trig(trig0), .st(st0)
    );

    fsm_trig_bench #(.THRESH(1)) u_dut1 (
        .clk(clk), .rst(rst_n), .en(en1), .x(x), .match_mask(mask), .match_val(val),
        .y(y1), .cnt(cnt1), .trig(trig1), .st(st1)
    );

    function automatic logic [YW-1:0] yexp(input logic [2:0] s, input logic [CW-1:0] c);
        logic [YW-1:0] r;
        r = '0;
        case (s)
            3'd1, 3'd2: begin
                r[CW:1] = c;
                r[0]    = 1'b1;
            end
            3'd3, 3'd4: r = '1;
            default:    r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            chk("d0_st",   32'(st0),   32'(e0.st));
            chk("d0_cnt",  32'(cnt0),  32'(e0.cnt));
            chk("d0_trig", 32'(trig0), 32'(e0.trig));
            chk("d0_y",    32'(y0),    32'(yexp(e0.st, e0.cnt)));
        end
    end

    always @(posedge clk) begin
        #1;
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("d1_st",   32'(st1),   32'(e1.st));
            chk("d1_cnt",  32'(cnt1),  32'(e1.cnt));
            chk("d1_trig", 32'(trig1), 32'(e1.trig));
            chk("d1_y",    32'(y1),    32'(yexp(e1.st, e1.cnt)));
        end
    end

    task automatic step0(input logic e, input logic [XW-1:0] xi,
                         input logic [2:0] s, input logic [CW-1:0] c, input logic t);
        exp_t tmp;
        en0 = e;
        x   = xi;
        tmp.st = s; tmp.cnt = c; tmp.trig = t;
        q0.push_back(tmp);
        @(negedge clk);
    endtask

    task automatic step1(input logic e, input logic [XW-1:0] xi,
                         input logic [2:0] s, input logic [CW-1:0] c, input logic t);
        exp_t tmp;
        en1 = e;
        x   = xi;
        tmp.st = s; tmp.cnt = c; tmp.trig = t;
        q1.push_back(tmp);
        @(negedge clk);
    endtask

    task automatic do_reset();
        en0   = 1'b0;
        en1   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_st",   32'(st0),   0);
        chk("rst_cnt",  32'(cnt0),  0);
        chk("rst_y",    32'(y0),    0);
        chk("rst_trig", 32'(trig0), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0;
        x = XN; mask = MASK; val = VAL;
        @(negedge clk);
        do_reset();

        // continuous matches: 0,1,2,2,2,2,3,4
        step0(1, XN, 1, 0, 0);
        step0(1, XM, 2, 1, 0);
        step0(1, XM, 2, 2, 0);
        step0(1, XM2, 2, 3, 0);
        step0(1, XM, 2, 4, 0);
        step0(1, XM, 3, 5, 1);
        step0(1, XM, 4, 5, 0);
`ifdef FSM_TRIG_STICKY_EN
        for (int i = 0; i < 10; i++) step0(0, XN, 4, 5, 0);
`else
        step0(0, XN, 0, 0, 0);
`endif

        // interleaved M,N,M,N,M,M,M
        do_reset();
        step0(1, XN, 1, 0, 0);
        step0(1, XM, 2, 1, 0);
        step0(1, XN, 2, 1, 0);
        step0(1, XM2, 2, 2, 0);
        step0(1, XN, 2, 2, 0);
        step0(1, XM, 2, 3, 0);
        step0(1, XM, 2, 4, 0);
        step0(1, XM, 3, 5, 1);
        step0(1, XN, 4, 5, 0);

        // en dropped with a simultaneous match at cnt=3
        do_reset();
        step0(1, XN, 1, 0, 0);
        step0(1, XM, 2, 1, 0);
        step0(1, XM, 2, 2, 0);
        step0(1, XM, 2, 3, 0);
        step0(0, XM, 0, 0, 0);

        // asynchronous reset while in FIRE
        do_reset();
        step0(1, XN, 1, 0, 0);
        step0(1, XM, 2, 1, 0);
        step0(1, XM, 2, 2, 0);
        step0(1, XM, 2, 3, 0);
        step0(1, XM, 2, 4, 0);
        step0(1, XM, 3, 5, 1);
        chk("fire_before_rst", 32'(trig0), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("fire_rst_trig", 32'(trig0), 0);
        chk("fire_rst_y",    32'(y0),    0);
        chk("fire_rst_cnt",  32'(cnt0),  0);
        chk("fire_rst_st",   32'(st0),   0);
        @(negedge clk);
        rst_n = 1'b1;
        step0(1, XN, 1, 0, 0);

        // THRESH=1 instance: first match fires directly
        do_reset();
        step1(1, XN, 1, 0, 0);
        step1(1, XM, 3, 1, 1);
        step1(1, XN, 4, 1, 0);
        step1(1, XM, 4, 1, 0);

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(q0.size() + q1.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
